window_min_max_tracker: RTL and testbench

//  Downstream consumer of three_bit_comparator. Accepts a stream of 3-bit samples (valid/ready).

---
 rtl/window_min_max_tracker_pkg.sv | 17 +
 rtl/three_bit_comparator.sv | 18 +
 rtl/window_min_max_tracker.sv | 110 +++++++++++
 tb/tb_window_min_max_tracker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/window_min_max_tracker_pkg.sv
// rtl/window_min_max_tracker_pkg.sv - shared types and constants for the window min/max tracker
package window_min_max_tracker_pkg;

  localparam int CMP_W = 3;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

endpackage

// File: rtl/three_bit_comparator.sv
// rtl/three_bit_comparator.sv - unsigned 3-bit magnitude comparator (a versus b)
import window_min_max_tracker_pkg::*;

module three_bit_comparator (
  input  logic [CMP_W-1:0] a,
  input  logic [CMP_W-1:0] b,
  output cmp_res_t         res
);

  // Exactly one of gt/lt/eq is set for any pair of inputs.
  always_comb begin
    res    = '0;
    res.gt = (a > b);
    res.lt = (a < b);
    res.eq = (a == b);
  end

endmodule

// File: rtl/window_min_max_tracker.sv
// rtl/window_min_max_tracker.sv - per-window min, max and repeat count over a 3-bit sample stream
import window_min_max_tracker_pkg::*;

module window_min_max_tracker #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMP_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CMP_W-1:0] out_min,
  output logic [CMP_W-1:0] out_max,
  output logic [CNT_W-1:0] out_rep_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CMP_W-1:0] min_q, max_q, prev_q;
  logic [CNT_W-1:0] rep_q;

  cmp_res_t min_res, max_res, rep_res;

  logic accept, first, last;

  // Only one field of each comparator result drives the datapath.
  logic unused_cmp_bits;
  assign unused_cmp_bits = &{min_res.gt, min_res.eq, max_res.lt, max_res.eq,
                             rep_res.gt, rep_res.lt};

  three_bit_comparator u_cmp_min (.a(in_data), .b(min_q),  .res(min_res));
  three_bit_comparator u_cmp_max (.a(in_data), .b(max_q),  .res(max_res));
  three_bit_comparator u_cmp_rep (.a(in_data), .b(prev_q), .res(rep_res));

  assign accept = in_valid && in_ready;
  assign first  = (cnt == '0);
  assign last   = (cnt == LAST_IDX);

  // Next state and in_ready, decoded from the state register only (no path from out_ready).
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_nxt = ST_ACCUM;
      end
      default: state_nxt = ST_ACCUM;
    endcase
  end

  // State register, sample counter and running min/max/prev/repeat registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_ACCUM;
      cnt    <= '0;
      min_q  <= '0;
      max_q  <= '0;
      prev_q <= '0;
      rep_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= last ? '0 : cnt + 1'b1;
        prev_q <= in_data;
        if (first) begin
          min_q <= in_data;
          max_q <= in_data;
          rep_q <= '0;
        end else begin
          if (min_res.lt) min_q <= in_data;
          if (max_res.gt) max_q <= in_data;
          if (rep_res.eq) rep_q <= rep_q + 1'b1;
        end
      end
    end
  end

  // Result registers: loaded with the final values including the closing sample, held until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_min     <= '0;
      out_max     <= '0;
      out_rep_cnt <= '0;
    end else if (accept && last) begin
      out_valid <= 1'b1;
      if (first) begin
        out_min     <= in_data;
        out_max     <= in_data;
        out_rep_cnt <= '0;
      end else begin
        out_min     <= min_res.lt ? in_data : min_q;
        out_max     <= max_res.gt ? in_data : max_q;
        out_rep_cnt <= rep_res.eq ? rep_q + 1'b1 : rep_q;
      end
    end else if (state == ST_HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_min_max_tracker.sv
// tb/tb_window_min_max_tracker.sv - directed self-checking bench for window_min_max_tracker
module tb_window_min_max_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid;
  logic [2:0] out_min, out_max;
  logic [3:0] out_rep_cnt;

  logic       v1 = 1'b0;
  logic [2:0] d1 = '0;
  logic       or1 = 1'b1;
  logic       ir1, ov1;
  logic [2:0] mn1, mx1;
  logic [3:0] rc1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  window_min_max_tracker #(.WINDOW(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min), .out_max(out_max),
    .out_rep_cnt(out_rep_cnt)
  );

  window_min_max_tracker #(.WINDOW(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_min(mn1), .out_max(mx1),
    .out_rep_cnt(rc1)
  );

  // Drive one sample for a single cycle; sampling point is 1 time unit after the edge.
  task automatic send(input logic [2:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, out_min, out_max, out_rep_cnt, in_ready} !== {1'b0, 3'd0, 3'd0, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: got v=%b min=%0d max=%0d rep=%0d rdy=%b want v=0 min=0 max=0 rep=0 rdy=1",
               out_valid, out_min, out_max, out_rep_cnt, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    logic [2:0] s [8] = '{3'd3, 3'd5, 3'd1, 3'd7, 3'd7, 3'd0, 3'd4, 3'd4};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(s[i]);
      if (i < 7) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL basic_early_valid: sample %0d got out_valid=%b want 0", i, out_valid);
        end
      end
    end
    checks++;
    if ({out_valid, out_min, out_max, out_rep_cnt, in_ready} !== {1'b1, 3'd0, 3'd7, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL basic_result: got v=%b min=%0d max=%0d rep=%0d rdy=%b want v=1 min=0 max=7 rep=2 rdy=0",
               out_valid, out_min, out_max, out_rep_cnt, in_ready);
    end
    idle(1);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL basic_pulse: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_all_equal;
    for (int i = 0; i < 8; i++) send(3'd5);
    checks++;
    if ({out_valid, out_min, out_max, out_rep_cnt} !== {1'b1, 3'd5, 3'd5, 4'd7}) begin
      failures++;
      $display("FAIL all_equal: got v=%b min=%0d max=%0d rep=%0d want v=1 min=5 max=5 rep=7",
               out_valid, out_min, out_max, out_rep_cnt);
    end
    idle(1);
  endtask

  task automatic test_backpressure;
    logic [2:0] s [8] = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd6, 3'd0, 3'd1, 3'd5};
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(s[i]);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_valid, in_ready, out_min, out_max, out_rep_cnt} !== {1'b1, 1'b0, 3'd0, 3'd6, 4'd2}) begin
        failures++;
        $display("FAIL hold_stable: cycle %0d got v=%b rdy=%b min=%0d max=%0d rep=%0d want v=1 rdy=0 min=0 max=6 rep=2",
                 c, out_valid, in_ready, out_min, out_max, out_rep_cnt);
      end
      in_valid = 1'b1;
      in_data  = 3'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_ready_comb: got in_ready=%b want 0 while out_ready rises", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL hold_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_gaps;
    for (int dir = 0; dir < 2; dir++) begin
      for (int i = 0; i < 8; i++) begin
        send(dir == 0 ? 3'(i) : 3'(7 - i));
        if (i % 2 == 1 && i < 7) begin
          idle(2);
          checks++;
          if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL gaps_early: dir %0d after %0d samples got out_valid=%b want 0", dir, i + 1, out_valid);
          end
        end
      end
      checks++;
      if ({out_valid, out_min, out_max, out_rep_cnt} !== {1'b1, 3'd0, 3'd7, 4'd0}) begin
        failures++;
        $display("FAIL gaps_result: dir %0d got v=%b min=%0d max=%0d rep=%0d want v=1 min=0 max=7 rep=0",
                 dir, out_valid, out_min, out_max, out_rep_cnt);
      end
      idle(1);
    end
  endtask

  task automatic test_mid_reset;
    logic [2:0] s [8] = '{3'd2, 3'd2, 3'd2, 3'd6, 3'd6, 3'd1, 3'd1, 3'd1};
    send(3'd7); send(3'd0); send(3'd3); send(3'd3);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_min, out_max, out_rep_cnt} !== {1'b0, 3'd0, 3'd0, 4'd0}) begin
      failures++;
      $display("FAIL async_reset: got v=%b min=%0d max=%0d rep=%0d want all 0",
               out_valid, out_min, out_max, out_rep_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(s[i]);
    checks++;
    if ({out_valid, out_min, out_max, out_rep_cnt} !== {1'b1, 3'd1, 3'd6, 4'd5}) begin
      failures++;
      $display("FAIL after_reset: got v=%b min=%0d max=%0d rep=%0d want v=1 min=1 max=6 rep=5",
               out_valid, out_min, out_max, out_rep_cnt);
    end
    idle(1);
  endtask

  task automatic test_window_one;
    logic [2:0] s [2] = '{3'd6, 3'd3};
    or1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ir1 !== 1'b1) begin
        failures++;
        $display("FAIL w1_ready: beat %0d got in_ready=%b want 1", i, ir1);
      end
      v1 = 1'b1;
      d1 = s[i];
      @(posedge clk); #1;
      checks++;
      if ({ov1, ir1, mn1, mx1, rc1} !== {1'b1, 1'b0, s[i], s[i], 4'd0}) begin
        failures++;
        $display("FAIL w1_beat: beat %0d got v=%b rdy=%b min=%0d max=%0d rep=%0d want v=1 rdy=0 min=%0d max=%0d rep=0",
                 i, ov1, ir1, mn1, mx1, rc1, s[i], s[i]);
      end
      @(posedge clk); #1;
      v1 = 1'b0;
      checks++;
      if ({ov1, ir1} !== 2'b01) begin
        failures++;
        $display("FAIL w1_bubble: beat %0d got v=%b rdy=%b want v=0 rdy=1", i, ov1, ir1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_equal();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_window_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
